program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer.sv | 146 ++++++++++++++
 tb/tb_program_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// ============================================================================
//  Module   : program_sequencer
//  Brief    : Steps a processor through a contiguous (wrapping) range of ROM
//             instructions with a per-instruction watchdog and abort.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module program_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              done,
    output logic [ADDR_W-1:0] Din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [ADDR_W:0]   instr_count
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] din_q, din_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        last_d  = last_q;
        count_d = count_q;
        wd_d    = wd_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_ISSUE;
                    din_d   = first_addr;
                    last_d  = last_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    wd_d    = '0;
                end
            end
            S_ISSUE: begin
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // abort beats done, and done on the watchdog's last cycle beats the timeout
                if (abort) begin
                    state_d = S_IDLE;
                end else if (done) begin
                    state_d = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    wd_d    = '0;
                    if (din_q == last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        din_d   = din_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it once registered
        run_d  = (state_d == S_ISSUE);
        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_NEXT);
        fin_d  = (state_d == S_FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            din_q   <= '0;
            last_q  <= '0;
            count_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            last_q  <= last_d;
            count_q <= count_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign Din         = din_q;
    assign run         = run_q;
    assign busy        = busy_q;
    assign finished    = fin_q;
    assign timeout_err = err_q;
    assign instr_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
//  Module   : tb_program_sequencer
//  Brief    : Scoreboard bench for program_sequencer with a processor model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [4:0] first_addr;
    logic [4:0] last_addr;
    logic       done;
    logic [4:0] Din;
    logic       run;
    logic       busy;
    logic       finished;
    logic       timeout_err;
    logic [5:0] instr_count;

    int n_checks = 0;
    int n_err    = 0;
    int exp_din[$];
    int exp_fin[$];
    int resp_dly = 3;
    bit resp_en  = 1'b0;

    program_sequencer #(.ADDR_W(5), .TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .done        (done),
        .Din         (Din),
        .run         (run),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (run) begin
            if (exp_din.size() == 0) check("unexpected_run", 1, 0);
            else check("run_din", int'(Din), exp_din.pop_front());
        end
        if (finished) begin
            if (exp_fin.size() == 0) check("unexpected_finished", 1, 0);
            else check("finish_count", int'(instr_count), exp_fin.pop_front());
        end
    end

    // Processor model: done is sampled resp_dly cycles after the run cycle
    initial begin
        done = 1'b0;
        forever begin
            @(negedge clock);
            while (run && resp_en) begin
                repeat (resp_dly) @(negedge clock);
                done = 1'b1;
                @(negedge clock);
                done = 1'b0;
                @(negedge clock);
                if (busy) check("done_to_run_latency", int'(run), 1);
            end
        end
    end

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        @(negedge clock);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        first_addr = ~f;
        last_addr  = ~l;
        check("start_to_run_latency", int'(run), 1);
    endtask

    task automatic wait_fin(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clock);
            if (finished) break;
        end
        check("finish_seen", int'(i < bound), 1);
    endtask

    initial begin
        int wcnt;
        int runs;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        repeat (3) @(negedge clock);
        check("rst_din", int'(Din), 0);
        check("rst_run", int'(run), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_instr_count", int'(instr_count), 0);
        reset = 1'b0;

        // Three instructions; a mid-run start with other addresses must be ignored
        resp_en  = 1'b1;
        resp_dly = 3;
        exp_din.push_back(0); exp_din.push_back(1); exp_din.push_back(2);
        exp_fin.push_back(3);
        do_start(5'd0, 5'd2);
        @(negedge clock);
        first_addr = 5'd20;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_fin(100);
        @(negedge clock);
        check("t1_busy_after", int'(busy), 0);
        check("t1_count_held", int'(instr_count), 3);
        check("t1_din_held", int'(Din), 2);

        // Single instruction
        resp_dly = 1;
        exp_din.push_back(5);
        exp_fin.push_back(1);
        do_start(5'd5, 5'd5);
        wait_fin(50);
        @(negedge clock);
        check("t2_count", int'(instr_count), 1);

        // Wrapping range
        resp_dly = 2;
        exp_din.push_back(30); exp_din.push_back(31);
        exp_din.push_back(0);  exp_din.push_back(1);
        exp_fin.push_back(4);
        do_start(5'd30, 5'd1);
        wait_fin(100);
        @(negedge clock);
        check("t3_count", int'(instr_count), 4);

        // Watchdog: done never comes
        resp_en = 1'b0;
        exp_din.push_back(7);
        do_start(5'd7, 5'd9);
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (timeout_err) break;
            if (busy && !run) wcnt++;
            @(negedge clock);
        end
        check("t4_wait_cycles", wcnt, 16);
        check("t4_timeout_err", int'(timeout_err), 1);
        check("t4_count", int'(instr_count), 0);
        check("t4_busy", int'(busy), 0);
        repeat (3) @(negedge clock);
        check("t4_err_sticky", int'(timeout_err), 1);
        check("t4_din_frozen", int'(Din), 7);
        resp_en  = 1'b1;
        resp_dly = 1;
        exp_din.push_back(7); exp_din.push_back(8);
        exp_fin.push_back(2);
        do_start(5'd7, 5'd8);
        check("t4_err_cleared", int'(timeout_err), 0);
        wait_fin(50);

        // done on the watchdog's final cycle, then abort in 2nd instruction's WAIT
        resp_dly = 16;
        exp_din.push_back(10); exp_din.push_back(11);
        do_start(5'd10, 5'd20);
        runs = 1;
        for (int i = 0; i < 60 && runs < 2; i++) begin
            @(negedge clock);
            if (run) runs++;
        end
        check("t5_second_run", runs, 2);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_run", int'(run), 0);
        check("t5_abort_count", int'(instr_count), 1);
        check("t5_no_timeout", int'(timeout_err), 0);
        repeat (25) @(negedge clock);

        // Reset in WAIT with start held high
        resp_en = 1'b0;
        exp_din.push_back(3);
        @(negedge clock);
        first_addr = 5'd3;
        last_addr  = 5'd3;
        start      = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_din", int'(Din), 0);
        check("t6_run", int'(run), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_finished", int'(finished), 0);
        check("t6_timeout_err", int'(timeout_err), 0);
        check("t6_count", int'(instr_count), 0);
        @(negedge clock);
        check("t6_run_in_reset", int'(run), 0);
        exp_din.push_back(3);
        exp_fin.push_back(1);
        resp_dly = 2;
        resp_en  = 1'b1;
        reset    = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check("t6_run_after_reset", int'(run), 1);
        wait_fin(50);
        repeat (3) @(negedge clock);

        check("exp_din_drained", exp_din.size(), 0);
        check("exp_fin_drained", exp_fin.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
